mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single CPU memory port (main Mem plus the video-memory write window) between two bus masters: port 0 = CPU, port 1 = DMA/blitter.
- Performs req/gnt/ack arbitration, latches the winning transaction and drives the Mem and VGA write strobes.
- Decodes the video region by the top address nibble.
- Sits between the masters and Mem/VGA in the top level, all on the CPU clock.

Parameters:
- RD_LAT, 1, Mem read latency in cycles from first mem_rd cycle to mem_rdata valid; legal range >=1.
- MEM_AW, 12, Mem word-address width; mem_addr = addr[MEM_AW-1:0].
- VM_REGION, 4'hA, value of addr[31:28] selecting video memory.

Ports:
- clk, input, 1, CPU clock.
- rst, input, 1, asynchronous active-high reset.
- m0_req / m1_req, input, 1, transaction request; held until ack.
- m0_addr / m1_addr, input, 32, byte address.
- m0_wdata / m1_wdata, input, 32, write data.
- m0_we / m1_we, input, 2, write strobe; 00 = none, nonzero = write size code passed through unchanged.
- m0_rd / m1_rd, input, 1, read request.
- m0_gnt / m1_gnt, output, 1, port owns the bus.
- m0_ack / m1_ack, output, 1, one-cycle completion pulse.
- m0_rdata / m1_rdata, output, 32, read data; valid only with ack.
- mem_addr, output, MEM_AW, Mem address.
- mem_wdata, output, 32, Mem/VGA write data.
- mem_we, output, 2, Mem write strobe.
- mem_rd, output, 1, Mem read enable.
- mem_rdata, input, 32, Mem read data.
- vm_addr, output, 28, video memory address = addr[27:0].
- vm_we, output, 2, video memory write strobe.

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset: state=IDLE; all gnt/ack=0, mem_we=0, vm_we=0, mem_rd=0; mem_addr, vm_addr, mem_wdata, rdata regs=0; last_owner=1, so port 0 wins the first contention.
- Reset mid-transaction: the transaction is dropped with no ack; the master must re-request.
- States: IDLE, ISSUE, WAIT, ACK. Outputs decode from the state and latched fields only; no combinational path from m*_ inputs to mem/vm outputs.
- IDLE:
  - No req: stay in IDLE.
  - One req: that port wins.
  - Both req: round-robin, granting the port != last_owner.
  - On the winning edge: latch addr/wdata/we/rd, set owner and last_owner, go to ISSUE.
- Decode: vm_hit = (addr[31:28]==VM_REGION).
- ISSUE (1 cycle), gnt[owner]=1. Cases in priority order:
  - we!=0 and vm_hit: vm_we=we, mem_we=0.
  - we!=0 and !vm_hit: mem_we=we, vm_we=0.
  - Any write: ack[owner]=1 this cycle, next state IDLE. rd is ignored whenever we!=0.
  - we==0, rd=1, !vm_hit: mem_rd=1, load counter=RD_LAT, go to WAIT.
  - we==0, rd=1, vm_hit: video is write-only; ack this cycle with rdata=0, next IDLE.
  - we==0, rd=0: no-op; ack this cycle, next IDLE.
- WAIT: mem_rd=1, mem_addr held, gnt held, counter decrements each cycle. In the last WAIT cycle (counter==1), mem_rdata is captured into m[owner]_rdata on the clock edge and the state goes to ACK.
- ACK (1 cycle): ack[owner]=1, gnt held, mem_rd=0; next IDLE.
- Latency from req sampled in IDLE at cycle 0:
  - Write: ack in cycle 1.
  - Read: ack in cycle 2+RD_LAT.
- gnt falls on the cycle after ack.
- A req still high in the IDLE cycle after ack is a new transaction.
- Non-owner gnt/ack are always 0.
- Non-owner rdata is unchanged and keeps its last value.
- A req deasserted before ack is a protocol violation; the latched transaction still completes.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; port 0 always wins simultaneous requests, and last_owner is unused.
- Undefined (default): round-robin as above.

Test Plan:
- Reset, then m0 write addr=0x00000010, we=2'b11, wdata=0xDEADBEEF -> mem_addr=0x010, mem_we=2'b11, vm_we=0, m0_ack in cycle 1, m0_gnt=0 in cycle 2.
- m1 write addr=0xA0000123, we=2'b01 -> vm_addr=0x0000123, vm_we=2'b01, mem_we=0, m1_ack in cycle 1.
- m0 read addr=0x00000020 with RD_LAT=1 and the memory model returning 0x12345678 -> mem_rd high in cycles 1-2, m0_ack plus rdata 0x12345678 in cycle 3. Repeat with RD_LAT=3 -> ack in cycle 5.
- m0 and m1 both requesting writes continuously for 4 transactions -> grant order 0,1,0,1. With MEM_ARB_FIXED_PRIO_EN defined -> 0,0,0,0 and m1 never acked.
- Read of addr=0xA0000000 -> ack in cycle 1, rdata=0, mem_rd never asserted.
- rst asserted during a read's WAIT state -> all outputs 0 immediately, no ack. After release, m0 read re-request completes normally.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - one master port of the memory bus arbiter
//
// Signals (master view):
//   req   : transaction request, held until ack
//   addr  : 32-bit byte address
//   wdata : 32-bit write data
//   we    : 2-bit write size code, 00 = no write
//   rd    : read request
//   gnt   : port owns the bus
//   ack   : one-cycle completion pulse
//   rdata : read data, valid only with ack
interface mem_bus_arbiter_if;
    logic        req;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  we;
    logic        rd;
    logic        gnt;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, addr, wdata, we, rd, input gnt, ack, rdata);
    modport slave  (input req, addr, wdata, we, rd, output gnt, ack, rdata);
endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master arbiter for the CPU Mem / video write port
//
// Port 0 = CPU, port 1 = DMA/blitter. Each master connects through a
// mem_bus_arbiter_if.slave modport. All outputs are registered.
//   clk, rst          : CPU clock, asynchronous active-high reset
//   m0, m1            : master ports (req/addr/wdata/we/rd in, gnt/ack/rdata out)
//   mem_addr_o        : Mem word address (addr[MEM_AW-1:0])
//   mem_wdata_o       : Mem/VGA write data
//   mem_we_o          : Mem write strobe
//   mem_rd_o          : Mem read enable
//   mem_rdata_i       : Mem read data, valid RD_LAT cycles after first mem_rd cycle
//   vm_addr_o         : video memory address (addr[27:0])
//   vm_we_o           : video memory write strobe
// Build option: MEM_ARB_FIXED_PRIO_EN selects fixed priority (port 0 wins)
// instead of round-robin.
module mem_bus_arbiter #(
    parameter int         RD_LAT    = 1,
    parameter int         MEM_AW    = 12,
    parameter logic [3:0] VM_REGION = 4'hA
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_bus_arbiter_if.slave      m0,
    mem_bus_arbiter_if.slave      m1,
    output logic [MEM_AW-1:0]     mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    output logic [1:0]            mem_we_o,
    output logic                  mem_rd_o,
    input  logic [31:0]           mem_rdata_i,
    output logic [27:0]           vm_addr_o,
    output logic [1:0]            vm_we_o
);
    localparam int CNT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t              state_q;
    logic                owner_q;
    logic [1:0]          gnt_q;
    logic [1:0]          ack_q;
    logic [31:0]         rdata0_q;
    logic [31:0]         rdata1_q;
    logic [MEM_AW-1:0]   mem_addr_q;
    logic [31:0]         mem_wdata_q;
    logic [1:0]          mem_we_q;
    logic                mem_rd_q;
    logic [27:0]         vm_addr_q;
    logic [1:0]          vm_we_q;
    logic [CNT_W-1:0]    cnt_q;
`ifndef MEM_ARB_FIXED_PRIO_EN
    logic                last_owner_q;
`endif

    // Arbitration decision and the winner's request fields, used only on the
    // IDLE edge; every output below is a register loaded from these.
    logic        win_valid_d;
    logic        win_d;
    logic [31:0] win_addr_d;
    logic [31:0] win_wdata_d;
    logic [1:0]  win_we_d;
    logic        win_rd_d;
    logic        win_vm_d;

    always_comb begin
        win_valid_d = m0.req | m1.req;
`ifdef MEM_ARB_FIXED_PRIO_EN
        win_d = ~m0.req;
`else
        if (m0.req && m1.req) begin
            win_d = ~last_owner_q;
        end else begin
            win_d = ~m0.req;
        end
`endif
        if (win_d) begin
            win_addr_d  = m1.addr;
            win_wdata_d = m1.wdata;
            win_we_d    = m1.we;
            win_rd_d    = m1.rd;
        end else begin
            win_addr_d  = m0.addr;
            win_wdata_d = m0.wdata;
            win_we_d    = m0.we;
            win_rd_d    = m0.rd;
        end
        win_vm_d = (win_addr_d[31:28] == VM_REGION);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            gnt_q        <= 2'b00;
            ack_q        <= 2'b00;
            rdata0_q     <= 32'h0;
            rdata1_q     <= 32'h0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'h0;
            mem_we_q     <= 2'b00;
            mem_rd_q     <= 1'b0;
            vm_addr_q    <= 28'h0;
            vm_we_q      <= 2'b00;
            cnt_q        <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_owner_q <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_valid_d) begin
                        owner_q     <= win_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
                        last_owner_q <= win_d;
`endif
                        gnt_q       <= win_d ? 2'b10 : 2'b01;
                        mem_addr_q  <= win_addr_d[MEM_AW-1:0];
                        vm_addr_q   <= win_addr_d[27:0];
                        mem_wdata_q <= win_wdata_d;
                        state_q     <= ISSUE;
                        // Write wins over rd; video space is write-only, so a
                        // video read completes immediately with zero data.
                        if (win_we_d != 2'b00) begin
                            ack_q <= win_d ? 2'b10 : 2'b01;
                            if (win_vm_d) begin
                                vm_we_q <= win_we_d;
                            end else begin
                                mem_we_q <= win_we_d;
                            end
                        end else if (win_rd_d && !win_vm_d) begin
                            mem_rd_q <= 1'b1;
                        end else begin
                            ack_q <= win_d ? 2'b10 : 2'b01;
                            if (win_rd_d) begin
                                if (win_d) begin
                                    rdata1_q <= 32'h0;
                                end else begin
                                    rdata0_q <= 32'h0;
                                end
                            end
                        end
                    end
                end
                ISSUE: begin
                    mem_we_q <= 2'b00;
                    vm_we_q  <= 2'b00;
                    ack_q    <= 2'b00;
                    if (mem_rd_q) begin
                        cnt_q   <= CNT_W'(RD_LAT);
                        state_q <= WAIT;
                    end else begin
                        gnt_q   <= 2'b00;
                        state_q <= IDLE;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        mem_rd_q <= 1'b0;
                        ack_q    <= gnt_q;
                        if (owner_q) begin
                            rdata1_q <= mem_rdata_i;
                        end else begin
                            rdata0_q <= mem_rdata_i;
                        end
                        state_q <= ACK;
                    end
                end
                ACK: begin
                    ack_q   <= 2'b00;
                    gnt_q   <= 2'b00;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m0.gnt      = gnt_q[0];
    assign m1.gnt      = gnt_q[1];
    assign m0.ack      = ack_q[0];
    assign m1.ack      = ack_q[1];
    assign m0.rdata    = rdata0_q;
    assign m1.rdata    = rdata1_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_we_o    = mem_we_q;
    assign mem_rd_o    = mem_rd_q;
    assign vm_addr_o   = vm_addr_q;
    assign vm_we_o     = vm_we_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mem_bus_arbiter_if a0();
    mem_bus_arbiter_if a1();
    mem_bus_arbiter_if b0();
    mem_bus_arbiter_if b1();

    logic [11:0] a_mem_addr, b_mem_addr;
    logic [31:0] a_mem_wdata, b_mem_wdata;
    logic [1:0]  a_mem_we, b_mem_we;
    logic        a_mem_rd, b_mem_rd;
    logic [31:0] a_mem_rdata, b_mem_rdata;
    logic [27:0] a_vm_addr, b_vm_addr;
    logic [1:0]  a_vm_we, b_vm_we;
    logic [7:0]  a_rd_cyc, b_rd_cyc;

    mem_bus_arbiter #(.RD_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .m0(a0.slave), .m1(a1.slave),
        .mem_addr_o(a_mem_addr), .mem_wdata_o(a_mem_wdata), .mem_we_o(a_mem_we),
        .mem_rd_o(a_mem_rd), .mem_rdata_i(a_mem_rdata),
        .vm_addr_o(a_vm_addr), .vm_we_o(a_vm_we)
    );

    mem_bus_arbiter #(.RD_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .m0(b0.slave), .m1(b1.slave),
        .mem_addr_o(b_mem_addr), .mem_wdata_o(b_mem_wdata), .mem_we_o(b_mem_we),
        .mem_rd_o(b_mem_rd), .mem_rdata_i(b_mem_rdata),
        .vm_addr_o(b_vm_addr), .vm_we_o(b_vm_we)
    );

    // Memory models: data is valid only RD_LAT cycles after mem_rd first rises.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rd_cyc <= 8'd0;
            b_rd_cyc <= 8'd0;
        end else begin
            a_rd_cyc <= a_mem_rd ? a_rd_cyc + 8'd1 : 8'd0;
            b_rd_cyc <= b_mem_rd ? b_rd_cyc + 8'd1 : 8'd0;
        end
    end
    assign a_mem_rdata = (a_mem_rd && a_rd_cyc == 8'd1) ? 32'h12345678 : 32'hBAD0BAD0;
    assign b_mem_rdata = (b_mem_rd && b_rd_cyc == 8'd3) ? 32'h12345678 : 32'hBAD0BAD0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        a0.req = 0; a0.addr = 0; a0.wdata = 0; a0.we = 0; a0.rd = 0;
        a1.req = 0; a1.addr = 0; a1.wdata = 0; a1.we = 0; a1.rd = 0;
        b0.req = 0; b0.addr = 0; b0.wdata = 0; b0.we = 0; b0.rd = 0;
        b1.req = 0; b1.addr = 0; b1.wdata = 0; b1.we = 0; b1.rd = 0;
    endtask

    task automatic test_reset();
        idle_all();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({a0.gnt, a1.gnt, a0.ack, a1.ack} !== 4'b0000) begin
            errors++; $display("FAIL reset_gnt_ack: got %b expected 0000", {a0.gnt, a1.gnt, a0.ack, a1.ack});
        end
        checks++;
        if ({a_mem_we, a_vm_we, a_mem_rd} !== 5'b0) begin
            errors++; $display("FAIL reset_strobes: got %b expected 00000", {a_mem_we, a_vm_we, a_mem_rd});
        end
        checks++;
        if (a_mem_addr !== 12'h0 || a_vm_addr !== 28'h0 || a_mem_wdata !== 32'h0) begin
            errors++; $display("FAIL reset_addr_data: got %h %h %h expected 0 0 0", a_mem_addr, a_vm_addr, a_mem_wdata);
        end
        checks++;
        if (a0.rdata !== 32'h0 || a1.rdata !== 32'h0) begin
            errors++; $display("FAIL reset_rdata: got %h %h expected 0 0", a0.rdata, a1.rdata);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_mem_write();
        a0.addr = 32'h00000010; a0.we = 2'b11; a0.wdata = 32'hDEADBEEF; a0.req = 1;
        step();
        checks++;
        if (a_mem_addr !== 12'h010 || a_mem_we !== 2'b11 || a_vm_we !== 2'b00) begin
            errors++; $display("FAIL mw_strobe: got addr=%h we=%b vm_we=%b expected 010 11 00", a_mem_addr, a_mem_we, a_vm_we);
        end
        checks++;
        if ({a0.gnt, a0.ack, a1.gnt, a1.ack} !== 4'b1100 || a_mem_wdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL mw_ack_c1: got %b %h expected 1100 deadbeef", {a0.gnt, a0.ack, a1.gnt, a1.ack}, a_mem_wdata);
        end
        a0.req = 0; a0.we = 0;
        step();
        checks++;
        if ({a0.gnt, a0.ack, a_mem_we} !== 4'b0000) begin
            errors++; $display("FAIL mw_c2: got %b expected 0000", {a0.gnt, a0.ack, a_mem_we});
        end
    endtask

    task automatic test_vm_write();
        a1.addr = 32'hA0000123; a1.we = 2'b01; a1.wdata = 32'hCAFEF00D; a1.req = 1;
        step();
        checks++;
        if (a_vm_addr !== 28'h0000123 || a_vm_we !== 2'b01 || a_mem_we !== 2'b00) begin
            errors++; $display("FAIL vw_strobe: got vm_addr=%h vm_we=%b mem_we=%b expected 0000123 01 00", a_vm_addr, a_vm_we, a_mem_we);
        end
        checks++;
        if ({a1.gnt, a1.ack, a0.gnt, a0.ack} !== 4'b1100) begin
            errors++; $display("FAIL vw_ack_c1: got %b expected 1100", {a1.gnt, a1.ack, a0.gnt, a0.ack});
        end
        a1.req = 0; a1.we = 0;
        step();
        checks++;
        if ({a1.gnt, a1.ack, a_vm_we} !== 4'b0000) begin
            errors++; $display("FAIL vw_c2: got %b expected 0000", {a1.gnt, a1.ack, a_vm_we});
        end
    endtask

    task automatic test_round_robin();
        int n;
        int order[4];
        int exp_order[4];
`ifdef MEM_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0};
`else
        exp_order = '{0, 1, 0, 1};
`endif
        n = 0;
        a0.addr = 32'h00000100; a0.we = 2'b11; a0.wdata = 32'h11111111; a0.req = 1;
        a1.addr = 32'h00000200; a1.we = 2'b11; a1.wdata = 32'h22222222; a1.req = 1;
        for (int c = 0; c < 40 && n < 4; c++) begin
            step();
            if (a0.ack || a1.ack) begin
                checks++;
                if (a0.ack && a1.ack) begin
                    errors++; $display("FAIL rr_dual_ack: got both acks expected one");
                end else if (a0.ack) begin
                    if (a1.gnt !== 1'b0) begin
                        errors++; $display("FAIL rr_nonowner_gnt: got m1_gnt=%b expected 0", a1.gnt);
                    end
                    order[n] = 0; n++;
                end else begin
                    if (a0.gnt !== 1'b0) begin
                        errors++; $display("FAIL rr_nonowner_gnt: got m0_gnt=%b expected 0", a0.gnt);
                    end
                    order[n] = 1; n++;
                end
            end
        end
        a0.req = 0; a0.we = 0; a1.req = 0; a1.we = 0;
        step();
        step();
        checks++;
        if (n != 4) begin
            errors++; $display("FAIL rr_count: got %0d acks expected 4", n);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (order[i] != exp_order[i]) begin
                errors++; $display("FAIL rr_order[%0d]: got port %0d expected port %0d", i, order[i], exp_order[i]);
            end
        end
    endtask

    task automatic test_read_lat1();
        a0.addr = 32'h00000020; a0.rd = 1; a0.req = 1;
        for (int c = 1; c <= 4; c++) begin
            step();
            checks++;
            if (a_mem_rd !== (c == 1 || c == 2) || a0.ack !== (c == 3)) begin
                errors++; $display("FAIL rd1_c%0d: got rd=%b ack=%b expected rd=%b ack=%b", c, a_mem_rd, a0.ack, (c == 1 || c == 2), (c == 3));
            end
            if (c == 1) begin
                checks++;
                if (a_mem_addr !== 12'h020) begin
                    errors++; $display("FAIL rd1_addr: got %h expected 020", a_mem_addr);
                end
            end
            if (c == 3) begin
                checks++;
                if (a0.rdata !== 32'h12345678 || a1.rdata !== 32'h0) begin
                    errors++; $display("FAIL rd1_rdata: got %h %h expected 12345678 00000000", a0.rdata, a1.rdata);
                end
                a0.req = 0; a0.rd = 0;
            end
        end
    endtask

    task automatic test_read_lat3();
        b0.addr = 32'h00000020; b0.rd = 1; b0.req = 1;
        for (int c = 1; c <= 6; c++) begin
            step();
            checks++;
            if (b_mem_rd !== (c >= 1 && c <= 4) || b0.ack !== (c == 5) || b0.gnt !== (c <= 5)) begin
                errors++; $display("FAIL rd3_c%0d: got rd=%b ack=%b gnt=%b expected rd=%b ack=%b gnt=%b", c, b_mem_rd, b0.ack, b0.gnt, (c <= 4), (c == 5), (c <= 5));
            end
            if (c == 5) begin
                checks++;
                if (b0.rdata !== 32'h12345678) begin
                    errors++; $display("FAIL rd3_rdata: got %h expected 12345678", b0.rdata);
                end
                b0.req = 0; b0.rd = 0;
            end
        end
    endtask

    task automatic test_vm_read();
        a0.addr = 32'hA0000000; a0.rd = 1; a0.req = 1;
        for (int c = 1; c <= 3; c++) begin
            step();
            checks++;
            if (a_mem_rd !== 1'b0 || a0.ack !== (c == 1)) begin
                errors++; $display("FAIL vr_c%0d: got rd=%b ack=%b expected rd=0 ack=%b", c, a_mem_rd, a0.ack, (c == 1));
            end
            if (c == 1) begin
                checks++;
                if (a0.rdata !== 32'h0) begin
                    errors++; $display("FAIL vr_rdata: got %h expected 00000000", a0.rdata);
                end
                a0.req = 0; a0.rd = 0;
            end
        end
    endtask

    task automatic test_reset_mid_read();
        a0.addr = 32'h00000030; a0.rd = 1; a0.req = 1;
        step();
        step();
        checks++;
        if (a_mem_rd !== 1'b1 || a0.gnt !== 1'b1) begin
            errors++; $display("FAIL rmr_wait: got rd=%b gnt=%b expected 1 1", a_mem_rd, a0.gnt);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({a0.gnt, a0.ack, a_mem_rd, a_mem_we, a_vm_we} !== 7'b0 || a_mem_addr !== 12'h0) begin
            errors++; $display("FAIL rmr_async: got %b addr=%h expected 0000000 000", {a0.gnt, a0.ack, a_mem_rd, a_mem_we, a_vm_we}, a_mem_addr);
        end
        step();
        checks++;
        if (a0.ack !== 1'b0 || a0.gnt !== 1'b0) begin
            errors++; $display("FAIL rmr_noack: got ack=%b gnt=%b expected 0 0", a0.ack, a0.gnt);
        end
        rst = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            step();
            checks++;
            if (a0.ack !== (c == 3)) begin
                errors++; $display("FAIL rmr_retry_c%0d: got ack=%b expected %b", c, a0.ack, (c == 3));
            end
            if (c == 3) begin
                checks++;
                if (a0.rdata !== 32'h12345678 || a_mem_addr !== 12'h030) begin
                    errors++; $display("FAIL rmr_retry_data: got %h addr=%h expected 12345678 030", a0.rdata, a_mem_addr);
                end
                a0.req = 0; a0.rd = 0;
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        test_reset();
        test_mem_write();
        test_vm_write();
        test_round_robin();
        test_read_lat1();
        test_read_lat3();
        test_vm_read();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
